gearbox_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one 132->128 gearbox among N_REQ 132-bit block sources.

---
 rtl/gbx_sched_pkg.sv | 14 +
 rtl/gbx_rr_arb.sv | 33 +++
 rtl/gearbox_rr_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_gearbox_rr_scheduler.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gbx_sched_pkg.sv
// Shared types and constants for the gearbox round-robin scheduler.
package gbx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        PAD
    } state_t;

    localparam int GBX_PERIOD = 32;
    localparam int BEAT_W = 5;
    localparam logic [131:0] PAD_BLOCK_DEF = 132'h1E;

endpackage

// File: rtl/gbx_rr_arb.sv
// Combinational round-robin picker; search starts just after last.
module gbx_rr_arb
    import gbx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  grant,
    output logic             any
);

    int j;

    // Walk offsets high to low so the nearest requester after last wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = N_REQ; i >= 1; i--) begin
            j = int'(last) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (req[j]) begin
                grant = ID_W'(j);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gearbox_rr_scheduler.sv
// Period-atomic round-robin feeder for a shared 132->128 gearbox.
// Define GBX_SCHED_STATS_EN to add per-requester period and pad counters.
module gearbox_rr_scheduler
    import gbx_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW = 132,
    parameter int BURST_PERIODS = 1,
    parameter int PAD_TIMEOUT = 8,
    parameter logic [DW-1:0] PAD_BLOCK = DW'(PAD_BLOCK_DEF),
    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_enable,
    input  logic [N_REQ-1:0]    cfg_mask,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                gbx_din_valid,
    output logic [DW-1:0]       gbx_din,
    input  logic                gbx_din_ready,
    output logic                gbx_sop,
    output logic [ID_W-1:0]     owner,
    output logic                owner_vld
`ifdef GBX_SCHED_STATS_EN
    ,
    output logic [N_REQ*32-1:0] stat_periods,
    output logic [31:0]         stat_pads
`endif
);

    localparam int IDL_W = 16;

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [7:0]         period_q, period_d;
    logic [IDL_W-1:0]   idle_q, idle_d;
    logic [ID_W-1:0]    owner_q, owner_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [ID_W-1:0]    pick;
    logic               any;
    logic               own_vld;
    logic               accept;
    logic               last_beat;
    logic               pad_hit;

    gbx_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req   (req_valid & ~cfg_mask),
        .last  (last_q),
        .grant (pick),
        .any   (any)
    );

    assign own_vld   = req_valid[owner_q];
    assign accept    = gbx_din_valid & gbx_din_ready;
    assign last_beat = (beat_q == BEAT_W'(GBX_PERIOD - 1));
    assign pad_hit   = (PAD_TIMEOUT > 0) &&
                       (idle_q == IDL_W'(PAD_TIMEOUT - 1));

    assign gbx_sop   = gbx_din_valid & (beat_q == '0);
    assign owner     = owner_q;
    assign owner_vld = (state_q != IDLE);

    // Owner path is a pure pass-through so the gearbox sees no added latency.
    always_comb begin
        gbx_din_valid = 1'b0;
        gbx_din       = '0;
        req_ready     = '0;
        unique case (state_q)
            OWN: begin
                gbx_din_valid      = own_vld;
                gbx_din            = req_data[int'(owner_q)*DW +: DW];
                req_ready[owner_q] = gbx_din_ready;
            end
            PAD: begin
                gbx_din_valid = 1'b1;
                gbx_din       = PAD_BLOCK;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        period_d = period_q;
        idle_d   = idle_q;
        owner_d  = owner_q;
        last_d   = last_q;
        unique case (state_q)
            IDLE: begin
                idle_d = '0;
                if (cfg_enable && any) begin
                    owner_d = pick;
                    last_d  = pick;
                    state_d = OWN;
                end
            end
            OWN: if (gbx_din_ready) begin
                if (own_vld) begin
                    beat_d = beat_q + 1'b1;
                    idle_d = '0;
                    if (last_beat) begin
                        if ((period_q + 8'd1 == 8'(BURST_PERIODS)) ||
                            !cfg_enable) begin
                            state_d  = IDLE;
                            period_d = '0;
                        end else begin
                            period_d = period_q + 8'd1;
                        end
                    end
                end else if (beat_q == '0) begin
                    state_d  = IDLE;
                    period_d = '0;
                end else if (pad_hit) begin
                    state_d = PAD;
                    idle_d  = '0;
                end else if (idle_q != '1) begin
                    idle_d = idle_q + 1'b1;
                end
            end
            PAD: if (gbx_din_ready) begin
                beat_d = beat_q + 1'b1;
                if (last_beat) begin
                    state_d  = IDLE;
                    period_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            period_q <= '0;
            idle_q   <= '0;
            owner_q  <= '0;
            last_q   <= ID_W'(N_REQ - 1);
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            period_q <= period_d;
            idle_q   <= idle_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
        end
    end

`ifdef GBX_SCHED_STATS_EN
    logic [N_REQ*32-1:0] per_q, per_d;
    logic [31:0]         pads_q, pads_d;

    // Pad-completed periods still belong to the owner that started them.
    always_comb begin
        per_d  = per_q;
        pads_d = pads_q;
        if (accept && last_beat &&
            per_q[int'(owner_q)*32 +: 32] != '1) begin
            per_d[int'(owner_q)*32 +: 32] =
                per_q[int'(owner_q)*32 +: 32] + 32'd1;
        end
        if (accept && (state_q == PAD) && pads_q != '1) begin
            pads_d = pads_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_q  <= '0;
            pads_q <= '0;
        end else begin
            per_q  <= per_d;
            pads_q <= pads_d;
        end
    end

    assign stat_periods = per_q;
    assign stat_pads    = pads_q;
`endif

endmodule

// File: tb/tb_gearbox_rr_scheduler.sv
// Randomized bench for gearbox_rr_scheduler against a period-level model.
module tb_gearbox_rr_scheduler;

    localparam int N  = 4;
    localparam int DW = 132;
    localparam int BP = 1;
    localparam int PT = 8;
    localparam logic [DW-1:0] PADV = 132'h1E;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cfg_enable = 1'b1;
    logic [N-1:0]    cfg_mask = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            gbx_din_valid;
    logic [DW-1:0]   gbx_din;
    logic            gbx_din_ready = 1'b1;
    logic            gbx_sop;
    logic [1:0]      owner;
    logic            owner_vld;
`ifdef GBX_SCHED_STATS_EN
    logic [N*32-1:0] stat_periods;
    logic [31:0]     stat_pads;
`endif

    gearbox_rr_scheduler #(
        .N_REQ         (N),
        .DW            (DW),
        .BURST_PERIODS (BP),
        .PAD_TIMEOUT   (PT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_mask      (cfg_mask),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .gbx_din_valid (gbx_din_valid),
        .gbx_din       (gbx_din),
        .gbx_din_ready (gbx_din_ready),
        .gbx_sop       (gbx_sop),
        .owner         (owner),
        .owner_vld     (owner_vld)
`ifdef GBX_SCHED_STATS_EN
        ,
        .stat_periods  (stat_periods),
        .stat_pads     (stat_pads)
`endif
    );

    always #5 clk = ~clk;

    int seq [N] = '{default: 0};
    int exp_seq [N];
    int off [N] = '{default: 0};

    bit m_busy, m_pad;
    int m_owner, m_last, m_beat, m_per, m_idle;
    int m_stp [N];
    int m_stpad;

    int n_chk = 0;
    int n_fail = 0;
    int dut_acc, dut_sop, pad_cnt, rdy2_pad;
    bit prev_vld;
    int dlog [$];
    logic       s_vld;
    logic [1:0] s_owner;

    function automatic logic [DW-1:0] mk(int i, int s);
        return (DW'(i + 1) << 64) | DW'(s);
    endfunction

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = mk(i, seq[i]);
        end
    end

    task automatic chk(string tag, logic [DW-1:0] got, logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        cfg_enable = 1'b1;
        cfg_mask = '0;
        gbx_din_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m_busy = 0; m_pad = 0; m_owner = 0; m_last = N - 1;
        m_beat = 0; m_per = 0; m_idle = 0; m_stpad = 0;
        for (int i = 0; i < N; i++) begin
            m_stp[i] = 0;
            exp_seq[i] = seq[i];
        end
        dut_acc = 0; dut_sop = 0; pad_cnt = 0; rdy2_pad = 0;
        prev_vld = 0;
        dlog.delete();
    endtask

    // Period-level model: who owns the gearbox and how far into the period.
    task automatic model_step(logic [N-1:0] rv, logic en,
                              logic [N-1:0] msk, logic rdy);
        bit found;
        int c;
        found = 0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (en && !found && rv[c] && !msk[c]) begin
                    found = 1;
                    m_owner = c; m_last = c; m_busy = 1; m_pad = 0;
                    m_beat = 0; m_per = 0; m_idle = 0;
                end
            end
        end else if (rdy) begin
            if (m_pad) begin
                m_stpad++;
                m_beat++;
                if (m_beat == 32) begin
                    m_stp[m_owner]++;
                    m_busy = 0; m_pad = 0; m_beat = 0;
                end
            end else if (rv[m_owner]) begin
                exp_seq[m_owner]++;
                m_beat++;
                m_idle = 0;
                if (m_beat == 32) begin
                    m_beat = 0;
                    m_per++;
                    m_stp[m_owner]++;
                    if (m_per == BP || !en) begin
                        m_busy = 0; m_per = 0;
                    end
                end
            end else if (m_beat == 0) begin
                m_busy = 0; m_per = 0;
            end else if (PT > 0 && m_idle == PT - 1) begin
                m_pad = 1; m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic step();
        logic          e_valid, e_sop;
        logic [DW-1:0] e_din;
        logic [N-1:0]  e_rdy, s_rdy;
        @(negedge clk);
        e_valid = 1'b0; e_din = '0; e_rdy = '0;
        if (m_busy && m_pad) begin
            e_valid = 1'b1;
            e_din = PADV;
        end else if (m_busy) begin
            e_valid = req_valid[m_owner];
            e_din = mk(m_owner, seq[m_owner]);
            e_rdy[m_owner] = gbx_din_ready;
        end
        e_sop = e_valid && (m_beat == 0);
        chk("din_valid", gbx_din_valid, e_valid);
        chk("din", gbx_din, e_din);
        chk("req_ready", req_ready, e_rdy);
        chk("sop", gbx_sop, e_sop);
        chk("owner_vld", owner_vld, m_busy);
        chk("owner", owner, m_owner);
        if (m_busy && !m_pad && e_valid && gbx_din_ready) begin
            chk("sb_data", gbx_din, mk(m_owner, exp_seq[m_owner]));
        end
        s_rdy = req_ready;
        s_vld = owner_vld;
        s_owner = owner;
        if (gbx_din_valid && gbx_din_ready) dut_acc++;
        if (gbx_sop) dut_sop++;
        if (gbx_din_valid && gbx_din_ready && gbx_din == PADV) pad_cnt++;
        if (gbx_din_valid && gbx_din == PADV && req_ready[2]) rdy2_pad++;
        if (s_vld && !prev_vld) dlog.push_back(int'(s_owner));
        prev_vld = s_vld;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (s_rdy[i] && req_valid[i]) seq[i]++;
        end
        model_step(req_valid, cfg_enable, cfg_mask, gbx_din_ready);
    endtask

    initial begin
        int n, n0;
        int bexp [5] = '{0, 1, 2, 3, 0};

        do_reset();
        chk("rst_valid", gbx_din_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_sop", gbx_sop, 0);
        chk("rst_owner", owner, 0);
        chk("rst_owner_vld", owner_vld, 0);
        chk("rst_din", gbx_din, 0);

        // Single requester, two back-to-back periods with a grant bubble.
        req_valid = 4'b0001;
        n = 0;
        while (dut_acc < 64 && n < 200) begin
            step();
            n++;
        end
        chk("A_accepts", dut_acc, 64);
        chk("A_cycles", n, 66);
        chk("A_sops", dut_sop, 2);

        // Everybody requesting: strict rotation, one period each.
        do_reset();
        req_valid = '1;
        repeat (170) step();
        chk("B_ngrants", dlog.size() >= 5, 1);
        for (int k = 0; k < 5; k++) begin
            if (k < dlog.size()) chk($sformatf("B_owner%0d", k), dlog[k], bexp[k]);
        end

        // Owner 2 stalls after 11 beats; remainder of the period is padded.
        do_reset();
        req_valid = 4'b0100;
        n = 0;
        while (dut_acc < 11 && n < 100) begin
            step();
            n++;
        end
        req_valid = 4'b1000;
        pad_cnt = 0;
        rdy2_pad = 0;
        n = 0;
        while (!(s_vld && s_owner == 2'd3) && n < 100) begin
            step();
            n++;
        end
        chk("C_pad_beats", pad_cnt, 21);
        chk("C_ready2_pad", rdy2_pad, 0);
        chk("C_next_owner", s_owner, 3);

        // Mask applied mid-period, then enable dropped mid-period.
        do_reset();
        req_valid = '1;
        n = 0;
        while (dlog.size() < 2 && n < 100) begin
            step();
            n++;
        end
        repeat (10) step();
        cfg_mask = 4'b0010;
        n = 0;
        while (dlog.size() < 5 && n < 200) begin
            step();
            n++;
        end
        chk("F_ngrants", dlog.size(), 5);
        if (dlog.size() >= 5) begin
            chk("F_skip1_a", dlog[2], 2);
            chk("F_skip1_b", dlog[3], 3);
            chk("F_skip1_c", dlog[4], 0);
        end
        repeat (5) step();
        cfg_enable = 1'b0;
        n0 = dlog.size();
        repeat (80) step();
        chk("F_no_grant", dlog.size(), n0);
        chk("F_idle", owner_vld, 0);

        // Random traffic, stalls, mask and enable changes.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (off[i] > 0) begin
                    off[i]--;
                    req_valid[i] = 1'b0;
                end else begin
                    req_valid[i] = 1'b1;
                    if ($urandom_range(0, 39) == 0) off[i] = $urandom_range(1, 14);
                end
            end
            gbx_din_ready = ((cyc % 33) != 32) && ($urandom_range(0, 9) != 0);
            if (cyc % 60 == 0) begin
                cfg_mask = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom_range(0, 15));
            end
            cfg_enable = (cyc % 500) < 450;
            step();
        end
`ifdef GBX_SCHED_STATS_EN
        chk("D_stat_pads", stat_pads, m_stpad);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("D_stat_per%0d", i), stat_periods[i*32 +: 32], m_stp[i]);
        end
`endif

        // Reset in the middle of owner 1's period.
        do_reset();
        req_valid = 4'b0010;
        n = 0;
        while (!(m_busy && m_beat == 17) && n < 100) begin
            step();
            n++;
        end
        chk("E_owner_pre", owner, 1);
        rst = 1'b1;
        #1;
        chk("E_valid", gbx_din_valid, 0);
        chk("E_ready", req_ready, 0);
        chk("E_sop", gbx_sop, 0);
        chk("E_owner", owner, 0);
        chk("E_owner_vld", owner_vld, 0);
        do_reset();
`ifdef GBX_SCHED_STATS_EN
        chk("E_stat_pads", stat_pads, 0);
        chk("E_stat_per", stat_periods, 0);
`endif
        req_valid = '1;
        step();
        chk("E_grant_vld", owner_vld, 1);
        chk("E_grant_owner", owner, 0);
        repeat (40) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
